// File: rtl/count_check_cw16.sv
`default_nettype none
// ============================================================================
//  Module      : count_check_cw16
//  Description : Frame-count checker. Watches the per-beat down-count tag
//                produced by an upstream counter, locks onto frame boundaries
//                (final beat with count 0) and forwards only beats whose
//                count and end-of-frame flag match the locally tracked
//                expectation. Mismatches are dropped, flagged with a one-cycle
//                pulse and tallied in a saturating 16-bit error counter.
//                Forwarded beats leave through a registered output stage with
//                a one-entry skid, giving full throughput and a registered
//                s_axis_tready.
//
//  Ports       : clk, sync_reset              clock / synchronous reset
//                s_axis_tvalid/tready/tdata   input beat handshake + payload
//                s_axis_count, s_axis_final_cnt  per-beat count tag and EOF
//                cnt_limit                    frame length minus one
//                m_axis_tvalid/tready/tdata/tlast  output beat stream
//                locked                       checker is tracking frames
//                err_pulse, err_count         mismatch pulse / saturating count
//
//  Revision    : 1.0  initial release
// ============================================================================
module count_check_cw16 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [15:0]           s_axis_count,
    input  logic                  s_axis_final_cnt,
    output logic                  s_axis_tready,
    input  logic [15:0]           cnt_limit,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [15:0]           err_count
);

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [15:0] c_ERR_MAX = 16'hFFFF;

    // ------------------------------------------------------------------
    // Checker state
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_expected;
    logic [15:0] w_expected_nxt;
    logic        r_err_pulse;
    logic [15:0] r_err_count;

    // ------------------------------------------------------------------
    // Output stage: main register plus one skid entry
    // ------------------------------------------------------------------
    logic                  r_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_last;

    logic w_accept;
    logic w_final_beat;
    logic w_match;
    logic w_fwd;
    logic w_mismatch;
    logic w_out_free;
    logic w_out_load_skid;
    logic w_out_load_in;
    logic w_skid_load;
    logic w_out_valid_nxt;
    logic w_skid_valid_nxt;

    // ------------------------------------------------------------------
    // Next-state / classification
    // ------------------------------------------------------------------
    always_comb begin
        w_accept       = s_axis_tvalid & r_ready & ~sync_reset;
        w_final_beat   = s_axis_final_cnt & (s_axis_count == 16'd0);
        w_match        = (s_axis_count == r_expected) &
                         (s_axis_final_cnt == (r_expected == 16'd0));
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_fwd          = 1'b0;
        w_mismatch     = 1'b0;

        if (w_accept) begin
            if (r_state == SEARCH) begin
                // Everything seen while searching is dropped; a frame end
                // gives us the phase, and the next frame starts at cnt_limit.
                if (w_final_beat) begin
                    w_state_nxt    = LOCKED;
                    w_expected_nxt = cnt_limit;
                end
            end else if (w_match) begin
                w_fwd = 1'b1;
                // The frame length is picked up only at the wrap, so a
                // cnt_limit change never disturbs a frame in flight.
                if (r_expected == 16'd0) begin
                    w_expected_nxt = cnt_limit;
                end else begin
                    w_expected_nxt = r_expected - 16'd1;
                end
            end else begin
                w_mismatch = 1'b1;
                if (w_final_beat) begin
                    // A frame end is still a valid phase reference: resync
                    // in place instead of dropping back to SEARCH.
                    w_expected_nxt = cnt_limit;
                end else begin
                    w_state_nxt    = SEARCH;
                    w_expected_nxt = 16'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state     <= SEARCH;
            r_expected  <= 16'd0;
            r_err_pulse <= 1'b0;
            r_err_count <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_expected  <= w_expected_nxt;
            r_err_pulse <= w_mismatch;
            if (w_mismatch && (r_err_count != c_ERR_MAX)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output buffer control. The skid only fills when a beat is forwarded
    // while the output register is stalled; s_axis_tready is the registered
    // inverse of skid occupancy, so the skid is always empty when a beat
    // can arrive.
    // ------------------------------------------------------------------
    always_comb begin
        w_out_free       = ~r_out_valid | m_axis_tready;
        w_out_load_skid  = w_out_free & r_skid_valid;
        w_out_load_in    = w_out_free & ~r_skid_valid & w_fwd;
        w_skid_load      = w_fwd & ~w_out_free;
        w_out_valid_nxt  = w_out_free ? (r_skid_valid | w_fwd) : 1'b1;
        w_skid_valid_nxt = w_skid_load | (r_skid_valid & ~w_out_free);
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_ready      <= ~w_skid_valid_nxt;
        end
    end

    // Payload registers carry no reset; their valid flags gate them.
    always_ff @(posedge clk) begin
        if (w_out_load_skid) begin
            r_out_data <= r_skid_data;
            r_out_last <= r_skid_last;
        end else if (w_out_load_in) begin
            r_out_data <= s_axis_tdata;
            r_out_last <= s_axis_final_cnt;
        end
        if (w_skid_load) begin
            r_skid_data <= s_axis_tdata;
            r_skid_last <= s_axis_final_cnt;
        end
    end

    assign s_axis_tready = r_ready;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;
    assign locked        = (r_state == LOCKED);
    assign err_pulse     = r_err_pulse;
    assign err_count     = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_count_check_cw16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_check_cw16
//  Description : Self-checking bench for count_check_cw16. A reference model
//                tracks lock state, the expected count and buffer occupancy
//                and pushes every beat that should be forwarded into a
//                scoreboard queue; an independent monitor compares the DUT
//                outputs against the model and pops the queue on handshakes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_count_check_cw16;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic          s_axis_tvalid;
    logic [DW-1:0] s_axis_tdata;
    logic [15:0]   s_axis_count;
    logic          s_axis_final_cnt;
    logic          s_axis_tready;
    logic [15:0]   cnt_limit;
    logic          m_axis_tvalid;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          locked;
    logic          err_pulse;
    logic [15:0]   err_count;

    always #5 clk = ~clk;

    count_check_cw16 #(.DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .sync_reset       (sync_reset),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_count     (s_axis_count),
        .s_axis_final_cnt (s_axis_final_cnt),
        .s_axis_tready    (s_axis_tready),
        .cnt_limit        (cnt_limit),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tready    (m_axis_tready),
        .locked           (locked),
        .err_pulse        (err_pulse),
        .err_count        (err_count)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_out    = 0;
    bit    m_mode   = 1'b0;   // 0: sink always ready, 1: ready ~30% of cycles

    // Reference model state (values valid after the most recent clock edge)
    bit          mdl_locked = 1'b0;
    logic [15:0] mdl_expected = 16'd0;
    logic [15:0] mdl_errcnt = 16'd0;
    bit          mdl_pulse = 1'b0;
    bit          mdl_ready = 1'b0;
    int          mdl_occ = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: evaluates each clock edge from bench-driven inputs.
    // ------------------------------------------------------------------
    always @(posedge clk) begin : model
        bit    acc;
        bit    pop;
        bit    fwd;
        bit    fin0;
        beat_t b;
        if (sync_reset) begin
            mdl_locked   = 1'b0;
            mdl_expected = 16'd0;
            mdl_errcnt   = 16'd0;
            mdl_pulse    = 1'b0;
            mdl_ready    = 1'b0;
            mdl_occ      = 0;
            sb_q.delete();
        end else begin
            acc       = s_axis_tvalid && mdl_ready;
            pop       = (mdl_occ > 0) && m_axis_tready;
            fwd       = 1'b0;
            mdl_pulse = 1'b0;
            if (acc) begin
                fin0 = s_axis_final_cnt && (s_axis_count == 16'd0);
                if (!mdl_locked) begin
                    if (fin0) begin
                        mdl_locked   = 1'b1;
                        mdl_expected = cnt_limit;
                    end
                end else if ((s_axis_count == mdl_expected) &&
                             (s_axis_final_cnt == (mdl_expected == 16'd0))) begin
                    fwd    = 1'b1;
                    b.data = s_axis_tdata;
                    b.last = s_axis_final_cnt;
                    sb_q.push_back(b);
                    mdl_expected = (mdl_expected == 16'd0) ? cnt_limit : mdl_expected - 16'd1;
                end else begin
                    mdl_pulse = 1'b1;
                    if (mdl_errcnt != 16'hFFFF) mdl_errcnt = mdl_errcnt + 16'd1;
                    if (fin0) mdl_expected = cnt_limit;
                    else      mdl_locked = 1'b0;
                end
            end
            mdl_occ   = mdl_occ - (pop ? 1 : 0) + (fwd ? 1 : 0);
            mdl_ready = (mdl_occ < 2);
        end
    end

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge, compares and pops.
    // ------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        beat_t f;
        check("locked", locked, mdl_locked);
        check("err_count", err_count, mdl_errcnt);
        check("err_pulse", err_pulse, mdl_pulse);
        check("s_axis_tready", s_axis_tready, mdl_ready);
        check("m_axis_tvalid", m_axis_tvalid, (mdl_occ > 0));
        if (m_axis_tvalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: got data %0h, no beat expected (t=%0t)", m_axis_tdata, $time);
            end else begin
                f = sb_q[0];
                check("m_axis_tdata", m_axis_tdata, f.data);
                check("m_axis_tlast", m_axis_tlast, f.last);
                if (m_axis_tready) begin
                    void'(sb_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    // Sink ready pattern
    always @(posedge clk) begin
        #1 m_axis_tready = m_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Driver tasks (called at posedge + 1)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] cnt, input bit fin);
        int waited;
        bit acc;
        waited           = 0;
        s_axis_tvalid    = 1'b1;
        s_axis_count     = cnt;
        s_axis_final_cnt = fin;
        s_axis_tdata     = $urandom;
        do begin
            @(negedge clk);
            acc = (s_axis_tready === 1'b1);
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 1000);
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: beat count %0d not accepted after %0d cycles", cnt, waited);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int top);
        for (int c = top; c >= 0; c--) send(16'(c), (c == 0));
    endtask

    task automatic pulse_reset();
        s_axis_tvalid = 1'b0;
        sync_reset    = 1'b1;
        @(posedge clk);
        #1;
        sync_reset    = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int          base;
        int          src;
        logic [15:0] cnt;
        bit          fin;

        sync_reset       = 1'b1;
        s_axis_tvalid    = 1'b0;
        s_axis_tdata     = '0;
        s_axis_count     = 16'd0;
        s_axis_final_cnt = 1'b0;
        cnt_limit        = 16'd3;
        m_axis_tready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tvalid", m_axis_tvalid, 1'b0);
        check("reset_tready", s_axis_tready, 1'b0);
        check("reset_locked", locked, 1'b0);
        check("reset_errcnt", err_count, 16'd0);
        sync_reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", s_axis_tready, 1'b1);

        // Lock and forward
        base = n_out;
        send(16'd1, 1'b0);
        send(16'd0, 1'b1);
        check("lock_after_final", locked, 1'b1);
        send_frame(3);
        idle(3);
        check("lock_fwd_beats", n_out - base, 4);

        // Mismatch on a final beat: resync, stay locked
        base = n_out;
        send(16'd3, 1'b0);
        send(16'd2, 1'b0);
        send(16'd0, 1'b1);
        idle(2);
        check("resync_errcnt", err_count, 16'd1);
        check("resync_locked", locked, 1'b1);
        send_frame(3);
        idle(3);
        check("resync_beats", n_out - base, 6);

        // Mismatch to SEARCH
        base = n_out;
        send(16'd3, 1'b0);
        send(16'd1, 1'b0);
        idle(2);
        check("search_errcnt", err_count, 16'd2);
        check("search_locked", locked, 1'b0);
        send(16'd2, 1'b0);
        send(16'd1, 1'b0);
        send(16'd0, 1'b1);
        idle(2);
        check("search_no_fwd", n_out - base, 1);
        send_frame(3);
        idle(3);
        check("search_relock_beats", n_out - base, 5);

        // Backpressure with cnt_limit=7
        base = n_out;
        cnt_limit = 16'd7;
        send_frame(3);
        m_mode = 1'b1;
        for (int f = 0; f < 4; f++) send_frame(7);
        m_mode = 1'b0;
        idle(6);
        check("bp_beats", n_out - base, 36);

        // Limit change mid-frame
        base = n_out;
        cnt_limit = 16'd3;
        send_frame(7);
        send(16'd3, 1'b0);
        send(16'd2, 1'b0);
        cnt_limit = 16'd1;
        send(16'd1, 1'b0);
        send(16'd0, 1'b1);
        send_frame(1);
        idle(3);
        check("limchg_beats", n_out - base, 14);
        check("limchg_errcnt", err_count, 16'd2);

        // cnt_limit = 0: one-beat frames
        base = n_out;
        cnt_limit = 16'd0;
        send_frame(1);
        for (int i = 0; i < 5; i++) send(16'd0, 1'b1);
        idle(3);
        check("lim0_beats", n_out - base, 7);

        // Reset mid-frame
        cnt_limit = 16'd3;
        send(16'd0, 1'b1);
        send(16'd3, 1'b0);
        send(16'd2, 1'b0);
        pulse_reset();
        check("midrst_tvalid", m_axis_tvalid, 1'b0);
        check("midrst_locked", locked, 1'b0);
        check("midrst_errcnt", err_count, 16'd0);
        @(posedge clk);
        #1;
        base = n_out;
        send(16'd1, 1'b0);
        send(16'd0, 1'b1);
        idle(2);
        check("midrst_dropped", n_out - base, 0);
        send_frame(3);
        idle(3);
        check("midrst_relock_beats", n_out - base, 4);

        // Randomized traffic with corrupted tags and limit changes
        m_mode = 1'b1;
        src = 3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if ($urandom_range(0, 19) == 0) cnt_limit = 16'($urandom_range(0, 5));
            cnt = 16'(src);
            fin = (src == 0);
            if ($urandom_range(0, 11) == 0) cnt = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) fin = ~fin;
            send(cnt, fin);
            src = (src == 0) ? int'(cnt_limit) : src - 1;
        end
        m_mode = 1'b0;
        idle(6);

        // Error counter saturation
        pulse_reset();
        @(posedge clk);
        #1;
        cnt_limit = 16'd3;
        send(16'd0, 1'b1);
        for (int i = 0; i < 65537; i++) send(16'd0, 1'b1);
        idle(3);
        check("sat_errcnt", err_count, 16'hFFFF);
        check("sat_locked", locked, 1'b1);

        idle(4);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
